// File: rtl/icache_ctrl_sequencer_if.sv
// Control bus between the instruction-cache control sequencer and the cache.
// The master side is the sequencer. The slave side is the command source together with the cache.
interface icache_ctrl_sequencer_if #(
    parameter int NB_CORES = 4
);
    logic                cmd_valid_i;
    logic                cmd_ready_o;
    logic [2:0]          cmd_op_i;
    logic [31:0]         cmd_arg_i;
    logic                rsp_valid_o;
    logic                rsp_err_o;
    logic                busy_o;
    logic                bypass_req_o;
    logic [NB_CORES:0]   bypass_ack_i;
    logic                flush_req_o;
    logic                flush_ack_i;
    logic                sel_flush_req_o;
    logic                sel_flush_ack_i;
    logic [31:0]         sel_flush_addr_o;
    logic                ctrl_clear_regs_o;
    logic                ctrl_enable_regs_o;

    modport master (
        input  cmd_valid_i, cmd_op_i, cmd_arg_i, bypass_ack_i, flush_ack_i, sel_flush_ack_i,
        output cmd_ready_o, rsp_valid_o, rsp_err_o, busy_o, bypass_req_o, flush_req_o,
               sel_flush_req_o, sel_flush_addr_o, ctrl_clear_regs_o, ctrl_enable_regs_o
    );

    modport slave (
        output cmd_valid_i, cmd_op_i, cmd_arg_i, bypass_ack_i, flush_ack_i, sel_flush_ack_i,
        input  cmd_ready_o, rsp_valid_o, rsp_err_o, busy_o, bypass_req_o, flush_req_o,
               sel_flush_req_o, sel_flush_addr_o, ctrl_clear_regs_o, ctrl_enable_regs_o
    );
endinterface

// File: rtl/icache_ctrl_sequencer.sv
// Runs one cache-control command at a time. Each handshake phase is bounded by a timeout.
// One response pulse is issued per command.
module icache_ctrl_sequencer #(
    parameter int NB_CORES       = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic                     clk_i,
    input logic                     rst_i,
    icache_ctrl_sequencer_if.master bus
);
    localparam int ACK_W = NB_CORES + 1;
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    localparam logic [2:0] OP_ENABLE    = 3'd0;
    localparam logic [2:0] OP_BYPASS    = 3'd1;
    localparam logic [2:0] OP_FLUSH     = 3'd2;
    localparam logic [2:0] OP_SEL_FLUSH = 3'd3;
    localparam logic [2:0] OP_CLR_CNT   = 3'd4;
    localparam logic [2:0] OP_CNT_EN    = 3'd5;

    typedef enum logic [2:0] {
        IDLE, BYP_WAIT, FL_REQ, FL_REL, SF_REQ, SF_REL
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             wait_done;
    logic             timed_out;

    // The bypass level completes once every port agrees with the requested level.
    function automatic logic byp_done(input logic [ACK_W-1:0] ack, input logic req);
        return req ? (&ack) : ~(|ack);
    endfunction

    always_comb begin
        wait_done = 1'b0;
        case (state)
            BYP_WAIT: wait_done = byp_done(bus.bypass_ack_i, bus.bypass_req_o);
            FL_REQ:   wait_done = bus.flush_ack_i;
            FL_REL:   wait_done = ~bus.flush_ack_i;
            SF_REQ:   wait_done = bus.sel_flush_ack_i;
            SF_REL:   wait_done = ~bus.sel_flush_ack_i;
            default:  wait_done = 1'b0;
        endcase
    end

    assign timed_out = (TIMEOUT_CYCLES != 0) && (cnt == CNT_MAX);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state                  <= IDLE;
            cnt                    <= '0;
            bus.cmd_ready_o        <= 1'b0;
            bus.rsp_valid_o        <= 1'b0;
            bus.rsp_err_o          <= 1'b0;
            bus.busy_o             <= 1'b0;
            bus.bypass_req_o       <= 1'b0;
            bus.flush_req_o        <= 1'b0;
            bus.sel_flush_req_o    <= 1'b0;
            bus.sel_flush_addr_o   <= '0;
            bus.ctrl_clear_regs_o  <= 1'b0;
            bus.ctrl_enable_regs_o <= 1'b0;
        end else begin
            bus.rsp_valid_o       <= 1'b0;
            bus.rsp_err_o         <= 1'b0;
            bus.ctrl_clear_regs_o <= 1'b0;
            case (state)
                IDLE: begin
                    bus.cmd_ready_o <= 1'b1;
                    bus.busy_o      <= 1'b0;
                    if (bus.cmd_valid_i && bus.cmd_ready_o) begin
                        cnt <= '0;
                        case (bus.cmd_op_i)
                            OP_ENABLE, OP_BYPASS: begin
                                bus.bypass_req_o <= (bus.cmd_op_i == OP_BYPASS);
                                bus.cmd_ready_o  <= 1'b0;
                                bus.busy_o       <= 1'b1;
                                state            <= BYP_WAIT;
                            end
                            OP_FLUSH: begin
                                bus.flush_req_o <= 1'b1;
                                bus.cmd_ready_o <= 1'b0;
                                bus.busy_o      <= 1'b1;
                                state           <= FL_REQ;
                            end
                            OP_SEL_FLUSH: begin
                                bus.sel_flush_addr_o <= bus.cmd_arg_i;
                                bus.sel_flush_req_o  <= 1'b1;
                                bus.cmd_ready_o      <= 1'b0;
                                bus.busy_o           <= 1'b1;
                                state                <= SF_REQ;
                            end
                            OP_CLR_CNT: begin
                                bus.ctrl_clear_regs_o <= 1'b1;
                                bus.rsp_valid_o       <= 1'b1;
                            end
                            OP_CNT_EN: begin
                                bus.ctrl_enable_regs_o <= bus.cmd_arg_i[0];
                                bus.rsp_valid_o        <= 1'b1;
                            end
                            default: begin
                                bus.rsp_valid_o <= 1'b1;
                                bus.rsp_err_o   <= 1'b1;
                            end
                        endcase
                    end
                end
                BYP_WAIT, FL_REQ, FL_REL, SF_REQ, SF_REL: begin
                    if (wait_done) begin
                        cnt <= '0;
                        case (state)
                            FL_REQ: begin
                                bus.flush_req_o <= 1'b0;
                                state           <= FL_REL;
                            end
                            SF_REQ: begin
                                bus.sel_flush_req_o <= 1'b0;
                                state               <= SF_REL;
                            end
                            default: begin
                                bus.rsp_valid_o <= 1'b1;
                                bus.cmd_ready_o <= 1'b1;
                                bus.busy_o      <= 1'b0;
                                state           <= IDLE;
                            end
                        endcase
                    end else if (timed_out) begin
                        // Abort: drop any flush request; the bypass level keeps its new value.
                        bus.flush_req_o     <= 1'b0;
                        bus.sel_flush_req_o <= 1'b0;
                        bus.rsp_valid_o     <= 1'b1;
                        bus.rsp_err_o       <= 1'b1;
                        bus.cmd_ready_o     <= 1'b1;
                        bus.busy_o          <= 1'b0;
                        state               <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_icache_ctrl_sequencer.sv
// Testbench for icache_ctrl_sequencer. It runs a table of directed commands, hand-written reset and idle sequences,
// and random commands checked against a transaction-level latency model.
module tb_icache_ctrl_sequencer;
    localparam int NB = 4;
    localparam int N  = 8;

    localparam logic [2:0] OP_ENABLE = 3'd0, OP_BYPASS = 3'd1, OP_FLUSH = 3'd2,
                           OP_SEL = 3'd3, OP_CLR = 3'd4, OP_CNT_EN = 3'd5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    icache_ctrl_sequencer_if #(.NB_CORES(NB)) bus ();

    icache_ctrl_sequencer #(.NB_CORES(NB), .TIMEOUT_CYCLES(N)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus.master)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cur    = 0;

    // Reference state tracked at command level.
    logic [4:0]  byp_ack_st = 5'h00;
    logic        exp_byp    = 1'b0;
    logic        exp_en     = 1'b0;
    logic [31:0] exp_addr   = 32'h0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] arg;
        int          a;
        int          b;
        int          lat;
        logic        err;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (txn %0d): got 0x%0h, expected 0x%0h at %0t", nm, cur, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Ack pattern while a bypass change is still in flight; it never matches the target.
    function automatic logic [4:0] pend(input logic ones, input int o);
        if (ones) return 5'((1 << (o % 5)) - 1);
        return 5'h1F >> ((o % 4) + 1);
    endfunction

    // Latency is the cycle offset from acceptance to the response pulse.
    // a is the delay from request to ack. b is the delay from entering the release phase to ack low.
    function automatic void model(input logic [2:0] op, input int a, input int b, input logic red,
                                  output int lat, output logic err);
        int ae;
        err = 1'b0;
        case (op)
            OP_ENABLE, OP_BYPASS: begin
                ae = red ? 0 : a;
                if (ae <= N) lat = ae + 2;
                else begin lat = N + 2; err = 1'b1; end
            end
            OP_FLUSH, OP_SEL: begin
                if (a > N)      begin lat = N + 2;     err = 1'b1; end
                else if (b > N) begin lat = a + N + 3; err = 1'b1; end
                else lat = a + b + 3;
            end
            OP_CLR, OP_CNT_EN: lat = 1;
            default: begin lat = 1; err = 1'b1; end
        endcase
    endfunction

    task automatic run_txn(input logic [2:0] op, input logic [31:0] arg, input int a, input int b,
                           input int lat, input logic err);
        logic [4:0] tgt, prev;
        logic       red, is_byp, fl_exp, sf_exp, ackv;
        int         req_len;
        is_byp  = (op == OP_ENABLE) || (op == OP_BYPASS);
        tgt     = (op == OP_BYPASS) ? 5'h1F : 5'h00;
        prev    = byp_ack_st;
        red     = (prev == tgt);
        req_len = (a <= N) ? a + 1 : N + 1;
        chk("cmd_ready_at_accept", bus.cmd_ready_o, 1'b1);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_op_i    = op;
        bus.cmd_arg_i   = arg;
        if (is_byp)         exp_byp  = tgt[0];
        if (op == OP_SEL)   exp_addr = arg;
        if (op == OP_CNT_EN) exp_en  = arg[0];
        for (int o = 1; o <= lat; o++) begin
            step();
            bus.cmd_valid_i = 1'b0;
            bus.cmd_op_i    = 3'($urandom);
            bus.cmd_arg_i   = $urandom;
            chk("rsp_valid", bus.rsp_valid_o, (o == lat));
            if (o == lat) chk("rsp_err", bus.rsp_err_o, err);
            chk("busy", bus.busy_o, (o < lat));
            chk("cmd_ready", bus.cmd_ready_o, (o == lat));
            chk("bypass_req", bus.bypass_req_o, exp_byp);
            chk("enable_regs", bus.ctrl_enable_regs_o, exp_en);
            chk("clear_regs", bus.ctrl_clear_regs_o, (op == OP_CLR) && (o == 1));
            chk("sel_flush_addr", bus.sel_flush_addr_o, exp_addr);
            fl_exp = (op == OP_FLUSH) && (o <= req_len);
            sf_exp = (op == OP_SEL) && (o <= req_len);
            chk("flush_req", bus.flush_req_o, fl_exp);
            chk("sel_flush_req", bus.sel_flush_req_o, sf_exp);
            // Cache-side responses for this cycle
            ackv = (a <= N) && (o >= 1 + a) && (o < a + 2 + b) && (o < lat);
            bus.flush_ack_i     = (op == OP_FLUSH) && ackv;
            bus.sel_flush_ack_i = (op == OP_SEL) && ackv;
            if (is_byp) begin
                if (red)                         bus.bypass_ack_i = tgt;
                else if (o == lat && err)        bus.bypass_ack_i = prev;
                else if (a <= N && o >= 1 + a)   bus.bypass_ack_i = tgt;
                else                             bus.bypass_ack_i = pend(tgt[0], o);
            end
        end
        byp_ack_st = bus.bypass_ack_i;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        logic err, red;
        logic [2:0] op;

        tbl[0]  = '{OP_FLUSH,  32'h0,          3,  2,  8, 1'b0};
        tbl[1]  = '{OP_FLUSH,  32'h0,          0,  0,  3, 1'b0};
        tbl[2]  = '{OP_FLUSH,  32'h0,          9,  0, 10, 1'b1};
        tbl[3]  = '{OP_FLUSH,  32'h0,          0,  9, 11, 1'b1};
        tbl[4]  = '{OP_SEL,    32'h1C00_8040,  1,  1,  5, 1'b0};
        tbl[5]  = '{OP_SEL,    32'hDEAD_BEEF, 10,  0, 10, 1'b1};
        tbl[6]  = '{OP_BYPASS, 32'h0,          4,  0,  6, 1'b0};
        tbl[7]  = '{OP_BYPASS, 32'h0,          3,  0,  2, 1'b0};
        tbl[8]  = '{OP_ENABLE, 32'h0,          2,  0,  4, 1'b0};
        tbl[9]  = '{OP_ENABLE, 32'h0,          5,  0,  2, 1'b0};
        tbl[10] = '{OP_BYPASS, 32'h0,          9,  0, 10, 1'b1};
        tbl[11] = '{OP_CNT_EN, 32'h1,          0,  0,  1, 1'b0};
        tbl[12] = '{OP_CLR,    32'h0,          0,  0,  1, 1'b0};
        tbl[13] = '{3'd7,      32'h0,          0,  0,  1, 1'b1};
        tbl[14] = '{3'd6,      32'h0,          0,  0,  1, 1'b1};
        tbl[15] = '{OP_ENABLE, 32'h0,          0,  0,  2, 1'b0};
        tbl[16] = '{OP_SEL,    32'h0000_1234,  8,  8, 19, 1'b0};
        tbl[17] = '{OP_CNT_EN, 32'h0,          0,  0,  1, 1'b0};

        bus.cmd_valid_i     = 1'b0;
        bus.cmd_op_i        = 3'd0;
        bus.cmd_arg_i       = 32'h0;
        bus.bypass_ack_i    = 5'h00;
        bus.flush_ack_i     = 1'b0;
        bus.sel_flush_ack_i = 1'b0;

        // Reset state
        rst = 1'b1;
        repeat (3) step();
        chk("rst_cmd_ready", bus.cmd_ready_o, 1'b0);
        chk("rst_rsp_valid", bus.rsp_valid_o, 1'b0);
        chk("rst_busy", bus.busy_o, 1'b0);
        chk("rst_bypass_req", bus.bypass_req_o, 1'b0);
        chk("rst_flush_req", bus.flush_req_o, 1'b0);
        chk("rst_sel_flush_req", bus.sel_flush_req_o, 1'b0);
        chk("rst_sel_flush_addr", bus.sel_flush_addr_o, 32'h0);
        chk("rst_enable_regs", bus.ctrl_enable_regs_o, 1'b0);
        rst = 1'b0;
        step();
        chk("cmd_ready_after_rst", bus.cmd_ready_o, 1'b1);

        // Directed table
        for (int i = 0; i < 18; i++) begin
            cur = i;
            run_txn(tbl[i].op, tbl[i].arg, tbl[i].a, tbl[i].b, tbl[i].lat, tbl[i].err);
        end

        // Ack glitches while idle are ignored
        cur = 100;
        bus.flush_ack_i     = 1'b1;
        bus.sel_flush_ack_i = 1'b1;
        bus.bypass_ack_i    = 5'h15;
        repeat (2) begin
            step();
            chk("glitch_busy", bus.busy_o, 1'b0);
            chk("glitch_rsp_valid", bus.rsp_valid_o, 1'b0);
            chk("glitch_flush_req", bus.flush_req_o, 1'b0);
            chk("glitch_cmd_ready", bus.cmd_ready_o, 1'b1);
        end
        bus.flush_ack_i     = 1'b0;
        bus.sel_flush_ack_i = 1'b0;
        bus.bypass_ack_i    = byp_ack_st;
        step();

        // Reset asserted during FL_REQ
        cur = 101;
        run_txn(OP_CNT_EN, 32'h1, 0, 0, 1, 1'b0);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_op_i    = OP_FLUSH;
        step();
        bus.cmd_valid_i = 1'b0;
        chk("midrst_flush_req_up", bus.flush_req_o, 1'b1);
        step();
        rst = 1'b1;
        step();
        chk("midrst_flush_req", bus.flush_req_o, 1'b0);
        chk("midrst_rsp_valid", bus.rsp_valid_o, 1'b0);
        chk("midrst_busy", bus.busy_o, 1'b0);
        chk("midrst_cmd_ready", bus.cmd_ready_o, 1'b0);
        chk("midrst_enable_regs", bus.ctrl_enable_regs_o, 1'b0);
        chk("midrst_sel_flush_addr", bus.sel_flush_addr_o, 32'h0);
        rst = 1'b0;
        step();
        chk("midrst_cmd_ready_after", bus.cmd_ready_o, 1'b1);
        chk("midrst_rsp_after", bus.rsp_valid_o, 1'b0);
        exp_byp  = 1'b0;
        exp_en   = 1'b0;
        exp_addr = 32'h0;

        // Random commands against the latency model
        for (int i = 0; i < 60; i++) begin
            int a, b;
            cur = 200 + i;
            op  = 3'($urandom_range(0, 7));
            a   = $urandom_range(0, 10);
            b   = $urandom_range(0, 10);
            red = (byp_ack_st == ((op == OP_BYPASS) ? 5'h1F : 5'h00));
            model(op, a, b, red, lat, err);
            run_txn(op, $urandom, a, b, lat, err);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
